// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues byte/half/word loads and stores over a
// req/ack data port and registers the MEM/WB bundle for writeback.
module mem_access #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ExMem_Valid,
  input  logic                  ExMem_MemRd,
  input  logic                  ExMem_MemWrt,
  input  logic [1:0]            ExMem_Size,
  input  logic                  ExMem_Unsigned,
  input  logic [DATA_WIDTH-1:0] ExMem_AluData,
  input  logic [DATA_WIDTH-1:0] ExMem_DataWrt,
  input  logic                  ExMem_WbSel,
  input  logic                  ExMem_RegWrt,
  input  logic [4:0]            ExMem_Rd,
  output logic                  Dmem_Req,
  output logic                  Dmem_We,
  output logic [ADDR_WIDTH-1:0] Dmem_Addr,
  output logic [DATA_WIDTH-1:0] Dmem_WData,
  output logic [3:0]            Dmem_Be,
  input  logic                  Dmem_Ack,
  input  logic [DATA_WIDTH-1:0] Dmem_RData,
  output logic                  Mem_Stall,
  output logic                  Mem_Misalign,
  output logic                  MemWb_Valid,
  output logic                  MemWb_WbSel,
  output logic                  MemWb_RegWrt,
  output logic [4:0]            MemWb_Rd,
  output logic [DATA_WIDTH-1:0] MemWb_AluData,
  output logic [DATA_WIDTH-1:0] MemWb_DataRd
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_reg;
  logic                  wb_sel_reg;
  logic                  reg_wrt_reg;
  logic [4:0]            rd_reg;
  logic [DATA_WIDTH-1:0] alu_reg;
  logic [1:0]            size_reg;
  logic                  zext_reg;
  logic                  is_load_reg;
  logic [1:0]            addr_lo_reg;

  logic                  is_mem;
  logic                  aligned;
  logic [1:0]            addr_lo;
  logic [3:0]            be_store;
  logic [DATA_WIDTH-1:0] wdata_store;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_data;

  assign addr_lo = ExMem_AluData[1:0];
  assign is_mem  = ExMem_Valid & (ExMem_MemRd | ExMem_MemWrt);

  always_comb begin
    aligned = 1'b0;
    case (ExMem_Size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Stall covers the accept cycle and every BUSY cycle until the ack arrives.
  assign Mem_Stall = rst_n & ((state_reg == IDLE) ? (is_mem & aligned) : ~Dmem_Ack);

  always_comb begin
    be_store    = 4'b1111;
    wdata_store = ExMem_DataWrt;
    case (ExMem_Size)
      2'b00: begin
        be_store    = 4'b0001 << addr_lo;
        wdata_store = {4{ExMem_DataWrt[7:0]}};
      end
      2'b01: begin
        be_store    = 4'b0011 << addr_lo;
        wdata_store = {2{ExMem_DataWrt[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = Dmem_RData >> {addr_lo_reg, 3'b000};

  always_comb begin
    load_data = lane;
    case (size_reg)
      2'b00:   load_data = {{24{~zext_reg & lane[7]}}, lane[7:0]};
      2'b01:   load_data = {{16{~zext_reg & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      Dmem_Req      <= 1'b0;
      Dmem_We       <= 1'b0;
      Dmem_Addr     <= '0;
      Dmem_WData    <= '0;
      Dmem_Be       <= 4'b0000;
      Mem_Misalign  <= 1'b0;
      MemWb_Valid   <= 1'b0;
      MemWb_WbSel   <= 1'b0;
      MemWb_RegWrt  <= 1'b0;
      MemWb_Rd      <= 5'd0;
      MemWb_AluData <= '0;
      MemWb_DataRd  <= '0;
      wb_sel_reg    <= 1'b0;
      reg_wrt_reg   <= 1'b0;
      rd_reg        <= 5'd0;
      alu_reg       <= '0;
      size_reg      <= 2'b00;
      zext_reg      <= 1'b0;
      is_load_reg   <= 1'b0;
      addr_lo_reg   <= 2'b00;
    end else begin
      Mem_Misalign <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (is_mem && aligned) begin
            Dmem_Req    <= 1'b1;
            Dmem_We     <= ExMem_MemWrt;
            Dmem_Addr   <= {ExMem_AluData[ADDR_WIDTH-1:2], 2'b00};
            Dmem_Be     <= ExMem_MemWrt ? be_store : 4'b0000;
            Dmem_WData  <= ExMem_MemWrt ? wdata_store : '0;
            wb_sel_reg  <= ExMem_WbSel;
            reg_wrt_reg <= ExMem_RegWrt;
            rd_reg      <= ExMem_Rd;
            alu_reg     <= ExMem_AluData;
            size_reg    <= ExMem_Size;
            zext_reg    <= ExMem_Unsigned;
            is_load_reg <= ExMem_MemRd;
            addr_lo_reg <= addr_lo;
            MemWb_Valid <= 1'b0;
            state_reg   <= BUSY;
          end else begin
            // A memory op reaching here is misaligned or illegal: retire it
            // without a request and suppress its register write.
            MemWb_Valid   <= ExMem_Valid;
            MemWb_WbSel   <= ExMem_WbSel;
            MemWb_RegWrt  <= ExMem_RegWrt & ~is_mem;
            MemWb_Rd      <= ExMem_Rd;
            MemWb_AluData <= ExMem_AluData;
            MemWb_DataRd  <= '0;
            Mem_Misalign  <= is_mem;
          end
        end
        BUSY: begin
          if (Dmem_Ack) begin
            Dmem_Req      <= 1'b0;
            Dmem_Be       <= 4'b0000;
            MemWb_Valid   <= 1'b1;
            MemWb_WbSel   <= wb_sel_reg;
            MemWb_RegWrt  <= reg_wrt_reg;
            MemWb_Rd      <= rd_reg;
            MemWb_AluData <= alu_reg;
            MemWb_DataRd  <= is_load_reg ? load_data : '0;
            state_reg     <= IDLE;
          end else begin
            MemWb_Valid <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table plus MEM/WB scoreboard.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ExMem_Valid, ExMem_MemRd, ExMem_MemWrt, ExMem_Unsigned;
  logic [1:0]  ExMem_Size;
  logic [31:0] ExMem_AluData, ExMem_DataWrt;
  logic        ExMem_WbSel, ExMem_RegWrt;
  logic [4:0]  ExMem_Rd;
  logic        Dmem_Req, Dmem_We, Dmem_Ack;
  logic [31:0] Dmem_Addr, Dmem_WData, Dmem_RData;
  logic [3:0]  Dmem_Be;
  logic        Mem_Stall, Mem_Misalign;
  logic        MemWb_Valid, MemWb_WbSel, MemWb_RegWrt;
  logic [4:0]  MemWb_Rd;
  logic [31:0] MemWb_AluData, MemWb_DataRd;

  mem_access #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ExMem_Valid(ExMem_Valid), .ExMem_MemRd(ExMem_MemRd), .ExMem_MemWrt(ExMem_MemWrt),
    .ExMem_Size(ExMem_Size), .ExMem_Unsigned(ExMem_Unsigned),
    .ExMem_AluData(ExMem_AluData), .ExMem_DataWrt(ExMem_DataWrt),
    .ExMem_WbSel(ExMem_WbSel), .ExMem_RegWrt(ExMem_RegWrt), .ExMem_Rd(ExMem_Rd),
    .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We), .Dmem_Addr(Dmem_Addr),
    .Dmem_WData(Dmem_WData), .Dmem_Be(Dmem_Be), .Dmem_Ack(Dmem_Ack), .Dmem_RData(Dmem_RData),
    .Mem_Stall(Mem_Stall), .Mem_Misalign(Mem_Misalign),
    .MemWb_Valid(MemWb_Valid), .MemWb_WbSel(MemWb_WbSel), .MemWb_RegWrt(MemWb_RegWrt),
    .MemWb_Rd(MemWb_Rd), .MemWb_AluData(MemWb_AluData), .MemWb_DataRd(MemWb_DataRd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] alu, dwr;
    logic [4:0]  rdi;
    logic        wbsel, regwrt;
    int          waits;
    logic [31:0] rdata, e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_data;
    logic        e_mis, e_regwrt;
  } vec_t;

  typedef struct {
    logic        wbsel, regwrt;
    logic [4:0]  rd;
    logic [31:0] alu, data;
    logic        mis;
  } exp_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];
  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every retired MEM/WB bundle must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && MemWb_Valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious_memwb: got MemWb_Valid=1 rd=%0d required no output", MemWb_Rd);
      end else begin
        mon_e = sb.pop_front();
        chk("memwb_wbsel",  32'(MemWb_WbSel),  32'(mon_e.wbsel));
        chk("memwb_regwrt", 32'(MemWb_RegWrt), 32'(mon_e.regwrt));
        chk("memwb_rd",     32'(MemWb_Rd),     32'(mon_e.rd));
        chk("memwb_alu",    MemWb_AluData,     mon_e.alu);
        chk("memwb_datard", MemWb_DataRd,      mon_e.data);
        chk("misalign",     32'(Mem_Misalign), 32'(mon_e.mis));
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   stalls;
    bit   accepted;
    accepted       = (v.rd | v.wr) & ~v.e_mis;
    ExMem_Valid    = 1'b1;
    ExMem_MemRd    = v.rd;
    ExMem_MemWrt   = v.wr;
    ExMem_Size     = v.size;
    ExMem_Unsigned = v.uns;
    ExMem_AluData  = v.alu;
    ExMem_DataWrt  = v.dwr;
    ExMem_Rd       = v.rdi;
    ExMem_WbSel    = v.wbsel;
    ExMem_RegWrt   = v.regwrt;
    e = '{wbsel: v.wbsel, regwrt: v.e_regwrt, rd: v.rdi, alu: v.alu, data: v.e_data, mis: v.e_mis};
    sb.push_back(e);
    stalls = 0;
    #1;
    if (Mem_Stall) stalls++;
    @(posedge clk); #1;
    if (accepted) begin
      for (int w = 0; w <= v.waits; w++) begin
        chk($sformatf("v%0d_req", idx), 32'(Dmem_Req), 32'd1);
        chk($sformatf("v%0d_we", idx), 32'(Dmem_We), 32'(v.wr));
        chk($sformatf("v%0d_addr", idx), Dmem_Addr, v.e_addr);
        chk($sformatf("v%0d_be", idx), 32'(Dmem_Be), 32'(v.e_be));
        if (v.wr) chk($sformatf("v%0d_wdata", idx), Dmem_WData, v.e_wdata);
        if (w == v.waits) begin
          Dmem_Ack   = 1'b1;
          Dmem_RData = v.rdata;
        end else begin
          Dmem_RData = 32'h5A5A5A5A;
        end
        #1;
        if (Mem_Stall) stalls++;
        @(posedge clk); #1;
      end
      Dmem_Ack = 1'b0;
      chk($sformatf("v%0d_req_drop", idx), 32'(Dmem_Req), 32'd0);
      chk($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.waits + 1));
      ExMem_Valid = 1'b0;
    end else begin
      ExMem_Valid = 1'b0;
      chk($sformatf("v%0d_no_req", idx), 32'(Dmem_Req), 32'd0);
      chk($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'd0);
      if (v.e_mis) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_misalign_pulse_end", idx), 32'(Mem_Misalign), 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            rd   wr   size   uns  alu           dwr           rdi    wbs  rw   wt rdata         e_addr        e_be   e_wdata       e_data        mis  e_rw
    vecs[0]  = '{1'b0,1'b0,2'b10,1'b0,32'h12345678,32'h00000000,5'd5, 1'b0,1'b1,0,32'h00000000,32'h00000000,4'h0,32'h00000000,32'h00000000,1'b0,1'b1};
    vecs[1]  = '{1'b1,1'b0,2'b00,1'b0,32'h00001003,32'h00000000,5'd7, 1'b1,1'b1,3,32'h80AABBCC,32'h00001000,4'h0,32'h00000000,32'hFFFFFF80,1'b0,1'b1};
    vecs[2]  = '{1'b1,1'b0,2'b00,1'b1,32'h00001003,32'h00000000,5'd8, 1'b1,1'b1,3,32'h80AABBCC,32'h00001000,4'h0,32'h00000000,32'h00000080,1'b0,1'b1};
    vecs[3]  = '{1'b0,1'b1,2'b01,1'b0,32'h00002002,32'h0000BEEF,5'd0, 1'b0,1'b0,2,32'h00000000,32'h00002000,4'hC,32'hBEEFBEEF,32'h00000000,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b0,2'b10,1'b0,32'h00003001,32'h00000000,5'd9, 1'b1,1'b1,0,32'h00000000,32'h00000000,4'h0,32'h00000000,32'h00000000,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,2'b01,1'b0,32'h00004002,32'h00000000,5'd10,1'b1,1'b1,1,32'h80017FFF,32'h00004000,4'h0,32'h00000000,32'hFFFF8001,1'b0,1'b1};
    vecs[6]  = '{1'b1,1'b0,2'b01,1'b1,32'h00004000,32'h00000000,5'd11,1'b1,1'b1,0,32'h8001F00D,32'h00004000,4'h0,32'h00000000,32'h0000F00D,1'b0,1'b1};
    vecs[7]  = '{1'b1,1'b0,2'b10,1'b0,32'h00005004,32'h00000000,5'd12,1'b1,1'b1,1,32'hDEADBEEF,32'h00005004,4'h0,32'h00000000,32'hDEADBEEF,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b1,2'b00,1'b0,32'h00006001,32'h000000A5,5'd0, 1'b0,1'b0,0,32'h00000000,32'h00006000,4'h2,32'hA5A5A5A5,32'h00000000,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,2'b10,1'b0,32'h00007000,32'hCAFEF00D,5'd0, 1'b0,1'b0,1,32'h00000000,32'h00007000,4'hF,32'hCAFEF00D,32'h00000000,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,2'b11,1'b0,32'h00008000,32'h00000000,5'd13,1'b1,1'b1,0,32'h00000000,32'h00000000,4'h0,32'h00000000,32'h00000000,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b1,2'b01,1'b0,32'h00009001,32'h12345678,5'd0, 1'b0,1'b0,0,32'h00000000,32'h00000000,4'h0,32'h00000000,32'h00000000,1'b1,1'b0};
    vecs[12] = '{1'b1,1'b0,2'b00,1'b0,32'h00001001,32'h00000000,5'd14,1'b1,1'b1,0,32'h12345678,32'h00001000,4'h0,32'h00000000,32'h00000056,1'b0,1'b1};
    vecs[13] = '{1'b0,1'b0,2'b00,1'b0,32'hFFFFFFFF,32'h00000000,5'd31,1'b0,1'b0,0,32'h00000000,32'h00000000,4'h0,32'h00000000,32'h00000000,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b0,2'b01,1'b1,32'h00001002,32'h00000000,5'd15,1'b1,1'b1,0,32'hFFFF1234,32'h00001000,4'h0,32'h00000000,32'h0000FFFF,1'b0,1'b1};

    // Reset held with a live load and a stray ack: everything must stay quiet.
    rst_n = 1'b0; Dmem_Ack = 1'b1; Dmem_RData = 32'hFFFFFFFF;
    ExMem_Valid = 1'b1; ExMem_MemRd = 1'b1; ExMem_MemWrt = 1'b0; ExMem_Size = 2'b10;
    ExMem_Unsigned = 1'b0; ExMem_AluData = 32'h00000100; ExMem_DataWrt = 32'h0;
    ExMem_WbSel = 1'b1; ExMem_RegWrt = 1'b1; ExMem_Rd = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",    32'(Dmem_Req),     32'd0);
    chk("rst_we",     32'(Dmem_We),      32'd0);
    chk("rst_addr",   Dmem_Addr,         32'd0);
    chk("rst_wdata",  Dmem_WData,        32'd0);
    chk("rst_be",     32'(Dmem_Be),      32'd0);
    chk("rst_stall",  32'(Mem_Stall),    32'd0);
    chk("rst_mis",    32'(Mem_Misalign), 32'd0);
    chk("rst_valid",  32'(MemWb_Valid),  32'd0);
    chk("rst_wbsel",  32'(MemWb_WbSel),  32'd0);
    chk("rst_regwrt", 32'(MemWb_RegWrt), 32'd0);
    chk("rst_rd",     32'(MemWb_Rd),     32'd0);
    chk("rst_alu",    MemWb_AluData,     32'd0);
    chk("rst_datard", MemWb_DataRd,      32'd0);
    ExMem_Valid = 1'b0; Dmem_Ack = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
      $display("vector %0d applied: addr=%h rd=%0d wr=%0d size=%0d", i, vecs[i].alu, vecs[i].rd, vecs[i].wr, vecs[i].size);
    end

    // Reset while BUSY abandons the request; a late ack must not retire anything.
    @(posedge clk); #1;
    ExMem_Valid = 1'b1; ExMem_MemRd = 1'b1; ExMem_MemWrt = 1'b0; ExMem_Size = 2'b10;
    ExMem_AluData = 32'h0000A000; ExMem_Rd = 5'd20;
    @(posedge clk); #1;
    chk("busy_rst_req_before", 32'(Dmem_Req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("busy_rst_req_drop", 32'(Dmem_Req), 32'd0);
    rst_n = 1'b1; ExMem_Valid = 1'b0; Dmem_Ack = 1'b1; Dmem_RData = 32'h11111111;
    #1;
    chk("busy_rst_stall", 32'(Mem_Stall), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("late_ack_valid", 32'(MemWb_Valid), 32'd0);
      chk("late_ack_req",   32'(Dmem_Req),    32'd0);
    end
    Dmem_Ack = 1'b0;
    $display("sequence reset_in_busy applied");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
